// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage data-bus sequencer. Turns the load/store request sitting in the
//   EX/MEM register into a single request/acknowledge transaction on the data
//   bus. It stalls the pipeline while the bus is busy. It flags misaligned
//   addresses and aborts transactions that are never acknowledged.
//
// Parameters
//   TIMEOUT  BUSY cycles without d_ack before the transaction is aborted (1..255)
//   WIDTH    data / address width
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   M_alu_res_i               byte address for loads/stores (ALU result)
//   M_rt_data_i               store data
//   M_rd_i                    destination register
//   M_mem_r_i, M_w_mem_ena_i  load / store request (both high = store)
//   M_w_reg_ena_i, M_wb_sel_i writeback controls
//   d_req, d_we, d_addr,      data-bus request, write strobe, address, write
//   d_wdata                   data (registered, stable while BUSY)
//   d_ack, d_rdata            data-bus completion and read data
//   mem_stall_o               hold EX/MEM and all earlier stages
//   M_mem_rdata_o             load data in the acknowledge cycle, else 0
//   M_alu_res_o, M_rd_o,      writeback controls towards MEM/WB
//   M_w_reg_ena_o, M_wb_sel_o
//   misalign_o, bus_err_o     one-cycle exception pulses
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst,

  input  logic [WIDTH-1:0] M_alu_res_i,
  input  logic [WIDTH-1:0] M_rt_data_i,
  input  logic [4:0]       M_rd_i,
  input  logic             M_mem_r_i,
  input  logic             M_w_mem_ena_i,
  input  logic             M_w_reg_ena_i,
  input  logic             M_wb_sel_i,

  output logic             d_req,
  output logic             d_we,
  output logic [WIDTH-1:0] d_addr,
  output logic [WIDTH-1:0] d_wdata,
  input  logic             d_ack,
  input  logic [WIDTH-1:0] d_rdata,

  output logic             mem_stall_o,
  output logic [WIDTH-1:0] M_mem_rdata_o,
  output logic [WIDTH-1:0] M_alu_res_o,
  output logic [4:0]       M_rd_o,
  output logic             M_w_reg_ena_o,
  output logic             M_wb_sel_o,
  output logic             misalign_o,
  output logic             bus_err_o
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  // Last wait-counter value before the abort fires.
  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e           state_q;
  logic [7:0]       cnt_q;
  logic             d_req_q;
  logic             d_we_q;
  logic [WIDTH-1:0] d_addr_q;
  logic [WIDTH-1:0] d_wdata_q;

  logic mem_op;
  logic aligned;
  logic issue;
  logic timeout_hit;
  logic finish;

  // A store wins when both request bits are set.
  assign mem_op  = M_mem_r_i | M_w_mem_ena_i;
  assign aligned = (M_alu_res_i[1:0] == 2'b00);

  assign issue       = (state_q == StIdle) & mem_op & aligned;
  // An acknowledge in the timeout cycle still completes normally.
  assign timeout_hit = (state_q == StBusy) & ~d_ack & (cnt_q == CntLast);
  assign finish      = (state_q == StBusy) & (d_ack | timeout_hit);

  // ---------------------------------------------------------------------------
  // Combinational outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_stall_o   = 1'b0;
    M_mem_rdata_o = '0;
    M_w_reg_ena_o = M_w_reg_ena_i;
    misalign_o    = 1'b0;
    bus_err_o     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (mem_op) begin
          if (aligned) begin
            // Hold the pipeline for the issue cycle.
            mem_stall_o = 1'b1;
          end else begin
            misalign_o    = 1'b1;
            M_w_reg_ena_o = 1'b0;
          end
        end
      end
      StBusy: begin
        if (d_ack) begin
          M_mem_rdata_o = d_we_q ? '0 : d_rdata;
        end else if (timeout_hit) begin
          bus_err_o     = 1'b1;
          M_w_reg_ena_o = 1'b0;
        end else begin
          mem_stall_o = 1'b1;
        end
      end
      default: begin
        mem_stall_o = 1'b0;
      end
    endcase
  end

  // Pass-through of the writeback fields.
  assign M_alu_res_o = M_alu_res_i;
  assign M_rd_o      = M_rd_i;
  assign M_wb_sel_o  = M_wb_sel_i;

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered bus outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      d_req_q   <= 1'b0;
      d_we_q    <= 1'b0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (issue) begin
            state_q   <= StBusy;
            cnt_q     <= '0;
            d_req_q   <= 1'b1;
            d_we_q    <= M_w_mem_ena_i;
            d_addr_q  <= M_alu_res_i;
            d_wdata_q <= M_rt_data_i;
          end
        end
        StBusy: begin
          if (finish) begin
            state_q <= StIdle;
            d_req_q <= 1'b0;
            d_we_q  <= 1'b0;
          end else if (cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          d_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign d_req   = d_req_q;
  assign d_we    = d_we_q;
  assign d_addr  = d_addr_q;
  assign d_wdata = d_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit. The bench plays both the pipeline (holding
// EX/MEM while stalled) and the data-bus slave. Each operation's expected
// cycle-by-cycle timeline is derived from its kind, alignment and the chosen
// acknowledge delay.
module tb_mem_access_unit;

  localparam int unsigned Timeout = 4;
  localparam int unsigned Width   = 32;

  logic             clk;
  logic             rst;
  logic [Width-1:0] alu_res;
  logic [Width-1:0] rt_data;
  logic [4:0]       rd;
  logic             mem_r;
  logic             w_mem;
  logic             wreg_i;
  logic             wbsel_i;
  logic             d_req;
  logic             d_we;
  logic [Width-1:0] d_addr;
  logic [Width-1:0] d_wdata;
  logic             d_ack;
  logic [Width-1:0] d_rdata;
  logic             stall;
  logic [Width-1:0] mem_rdata;
  logic [Width-1:0] alu_o;
  logic [4:0]       rd_o;
  logic             wreg_o;
  logic             wbsel_o;
  logic             misalign;
  logic             bus_err;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(
    .TIMEOUT (Timeout),
    .WIDTH   (Width)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .M_alu_res_i   (alu_res),
    .M_rt_data_i   (rt_data),
    .M_rd_i        (rd),
    .M_mem_r_i     (mem_r),
    .M_w_mem_ena_i (w_mem),
    .M_w_reg_ena_i (wreg_i),
    .M_wb_sel_i    (wbsel_i),
    .d_req         (d_req),
    .d_we          (d_we),
    .d_addr        (d_addr),
    .d_wdata       (d_wdata),
    .d_ack         (d_ack),
    .d_rdata       (d_rdata),
    .mem_stall_o   (stall),
    .M_mem_rdata_o (mem_rdata),
    .M_alu_res_o   (alu_o),
    .M_rd_o        (rd_o),
    .M_w_reg_ena_o (wreg_o),
    .M_wb_sel_o    (wbsel_o),
    .misalign_o    (misalign),
    .bus_err_o     (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input logic e_stall, input logic e_req,
                             input logic e_we, input logic [31:0] e_addr,
                             input logic [31:0] e_wdata, input logic [31:0] e_rdata,
                             input logic e_wreg, input logic e_mis, input logic e_err,
                             input bit bus_chk);
    check({tag, ".stall"}, 32'(stall), 32'(e_stall));
    check({tag, ".d_req"}, 32'(d_req), 32'(e_req));
    if (bus_chk) begin
      check({tag, ".d_we"}, 32'(d_we), 32'(e_we));
      check({tag, ".d_addr"}, d_addr, e_addr);
      check({tag, ".d_wdata"}, d_wdata, e_wdata);
    end
    check({tag, ".rdata"}, mem_rdata, e_rdata);
    check({tag, ".wreg"}, 32'(wreg_o), 32'(e_wreg));
    check({tag, ".misalign"}, 32'(misalign), 32'(e_mis));
    check({tag, ".bus_err"}, 32'(bus_err), 32'(e_err));
    check({tag, ".alu_res"}, alu_o, alu_res);
    check({tag, ".rd"}, 32'(rd_o), 32'(rd));
    check({tag, ".wb_sel"}, 32'(wbsel_o), 32'(wbsel_i));
  endtask

  // kind: 0 = ALU op, 1 = load, 2 = store, 3 = load+store (acts as store).
  // ack_at: BUSY cycle index (0-based) in which the slave acknowledges;
  // any value >= Timeout means the slave never answers.
  task automatic do_op(input string tag, input int kind, input logic [31:0] addr,
                       input logic [31:0] data, input int ack_at);
    logic       is_st;
    logic       is_op;
    logic       al;
    logic [1:0] lo;
    mem_r   = (kind == 1) || (kind == 3);
    w_mem   = (kind >= 2);
    alu_res = addr;
    rt_data = data;
    rd      = 5'($urandom);
    wreg_i  = 1'($urandom);
    wbsel_i = 1'($urandom);
    is_st   = w_mem;
    is_op   = mem_r | w_mem;
    lo      = addr[1:0];
    al      = (lo == 2'b00);
    // Acknowledges while idle must be ignored.
    d_ack   = 1'($urandom);
    d_rdata = $urandom;
    @(negedge clk);
    if (!is_op)
      check_cycle({tag, ".alu"}, 1'b0, 1'b0, 1'b0, 0, 0, 0, wreg_i, 1'b0, 1'b0, 1'b0);
    else if (!al)
      check_cycle({tag, ".mis"}, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    else
      check_cycle({tag, ".issue"}, 1'b1, 1'b0, 1'b0, 0, 0, 0, wreg_i, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    if (is_op && al) begin
      for (int j = 0; j < int'(Timeout); j++) begin
        d_ack   = (j == ack_at);
        d_rdata = $urandom;
        @(negedge clk);
        if (j == ack_at)
          check_cycle({tag, ".ack"}, 1'b0, 1'b1, is_st, addr, data, is_st ? 32'd0 : d_rdata,
                      wreg_i, 1'b0, 1'b0, 1'b1);
        else if (j == int'(Timeout) - 1)
          check_cycle({tag, ".tmo"}, 1'b0, 1'b1, is_st, addr, data, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        else
          check_cycle({tag, ".wait"}, 1'b1, 1'b1, is_st, addr, data, 0, wreg_i, 1'b0, 1'b0,
                      1'b1);
        @(posedge clk);
        #1;
        if (j == ack_at) break;
      end
    end
    d_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int          k;
    rst = 1'b1;
    {mem_r, w_mem, wreg_i, wbsel_i, d_ack} = '0;
    alu_res = '0;
    rt_data = '0;
    rd      = '0;
    d_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.d_req", 32'(d_req), 0);
    check("reset.d_we", 32'(d_we), 0);
    check("reset.d_addr", d_addr, 0);
    check("reset.d_wdata", d_wdata, 0);
    check("reset.stall", 32'(stall), 0);
    check("reset.bus_err", 32'(bus_err), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed scenarios.
    do_op("load100", 1, 32'h100, 32'h0, 0);
    do_op("store104", 2, 32'h104, 32'h12345678, 3);
    do_op("load102", 1, 32'h102, 32'h0, 0);
    do_op("timeout", 1, 32'h10, 32'h0, 99);
    do_op("ack_last", 1, 32'h20, 32'h0, int'(Timeout) - 1);
    do_op("both", 3, 32'h40, 32'hCAFEF00D, 1);
    do_op("b2b_ld", 1, 32'h80, 32'h0, 0);
    do_op("b2b_alu", 0, 32'h7, 32'h0, 0);

    // Asynchronous reset in the middle of a BUSY transaction.
    mem_r   = 1'b1;
    w_mem   = 1'b0;
    alu_res = 32'h200;
    rt_data = 32'h55;
    d_ack   = 1'b0;
    @(posedge clk);
    #3;
    check("rstmid.busy_req", 32'(d_req), 1);
    rst = 1'b1;
    #1;
    check("rstmid.d_req", 32'(d_req), 0);
    check("rstmid.d_addr", d_addr, 0);
    check("rstmid.bus_err", 32'(bus_err), 0);
    mem_r = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_op("after_rst", 1, 32'h100, 32'h0, 1);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      k = int'($urandom_range(0, 3));
      do_op("rnd", k, a, $urandom, int'($urandom_range(0, 6)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
